// File: rtl/tdm_demux.sv
// 4-slot TDM demultiplexer: hunts for a frame marker, then collects slots 0-3 into
// shadow registers and publishes all four lanes together one cycle after slot 3.
module tdm_demux #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         in_valid,
  input  logic         in_sync,
  output logic [W-1:0] z0,
  output logic [W-1:0] z1,
  output logic [W-1:0] z2,
  output logic [W-1:0] z3,
  output logic         frame_valid,
  output logic         locked,
  output logic         sync_err,
  output logic [1:0]   slot
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t       state;
  logic [W-1:0] sh0, sh1, sh2;

  assign locked = (state == LOCK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= 2'd0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      z0          <= '0;
      z1          <= '0;
      z2          <= '0;
      z3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (in_valid) begin
        if (state == HUNT) begin
          if (in_sync) begin
            sh0   <= din;
            slot  <= 2'd1;
            state <= LOCK;
          end
        end else if (in_sync) begin
          // A marker mid-frame drops the partial frame and restarts at slot 0.
          sh0  <= din;
          slot <= 2'd1;
          if (slot != 2'd0) sync_err <= 1'b1;
        end else begin
          case (slot)
            2'd0: begin
              sync_err <= 1'b1;
              state    <= HUNT;
              slot     <= 2'd0;
            end
            2'd1: begin
              sh1  <= din;
              slot <= 2'd2;
            end
            2'd2: begin
              sh2  <= din;
              slot <= 2'd3;
            end
            default: begin
              z0          <= sh0;
              z1          <= sh1;
              z2          <= sh2;
              z3          <= din;
              frame_valid <= 1'b1;
              slot        <= 2'd0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized and directed scoreboard bench for tdm_demux against a queue-based frame model.
module tb_tdm_demux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = '0;
  logic       in_valid = 1'b0;
  logic       in_sync = 1'b0;
  logic [3:0] z0, z1, z2, z3;
  logic       frame_valid, locked, sync_err;
  logic [1:0] slot;

  tdm_demux #(.W(4)) dut (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_sync(in_sync),
    .z0(z0), .z1(z1), .z2(z2), .z3(z3),
    .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err), .slot(slot)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic       lk;
    logic [1:0] sl;
    logic       fv;
    logic       se;
    logic [15:0] z;
  } status_t;

  typedef struct {
    int          tag;
    logic [15:0] z;
  } frame_t;

  status_t sq[$];
  frame_t  fq[$];
  int compared = 0;
  int mismatched = 0;
  int edge_cnt = 0;

  // Reference model: a frame in progress is just the list of samples gathered so far.
  bit         m_locked = 0;
  logic [3:0] m_buf[$];
  logic [15:0] m_z = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit s, input logic [3:0] d);
    status_t st;
    frame_t  fr;
    bit fv, se;
    @(negedge clk);
    rst = r; in_valid = v; in_sync = s; din = d;
    fv = 0; se = 0;
    if (r) begin
      m_locked = 0;
      m_buf.delete();
      m_z = '0;
    end else if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_buf.delete();
          m_buf.push_back(d);
          m_locked = 1;
        end
      end else if (s) begin
        if (m_buf.size() != 0) se = 1;
        m_buf.delete();
        m_buf.push_back(d);
      end else if (m_buf.size() == 0) begin
        se = 1;
        m_locked = 0;
      end else begin
        m_buf.push_back(d);
        if (m_buf.size() == 4) begin
          m_z = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
          fv = 1;
          m_buf.delete();
        end
      end
    end
    st.tag = edge_cnt + 1;
    st.lk  = m_locked;
    st.sl  = 2'(m_buf.size());
    st.fv  = fv;
    st.se  = se;
    st.z   = m_z;
    sq.push_back(st);
    if (fv) begin
      fr.tag = edge_cnt + 1;
      fr.z   = m_z;
      fq.push_back(fr);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, $urandom_range(0, 1) == 1, 4'($urandom));
  endtask

  task automatic frame4(input logic [3:0] a, b, c, d);
    step(0, 1, 1, a); step(0, 1, 0, b); step(0, 1, 0, c); step(0, 1, 0, d);
  endtask

  // Monitor: checks per-edge status and pops the frame scoreboard on each frame_valid.
  initial begin
    status_t st;
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      if (frame_valid === 1'b1) begin
        if (fq.size() == 0 || fq[0].tag != edge_cnt) begin
          chk("unexpected_frame_valid", 32'(frame_valid), 32'd0);
        end else begin
          chk("frame_lanes", {16'd0, z3, z2, z1, z0}, {16'd0, fq[0].z});
          void'(fq.pop_front());
        end
      end
      while (fq.size() > 0 && fq[0].tag < edge_cnt) begin
        chk("missing_frame_valid", 32'(frame_valid), 32'd1);
        void'(fq.pop_front());
      end
      if (sq.size() > 0 && sq[0].tag == edge_cnt) begin
        st = sq.pop_front();
        chk("locked", 32'(locked), 32'(st.lk));
        chk("slot", 32'(slot), 32'(st.sl));
        chk("sync_err", 32'(sync_err), 32'(st.se));
        chk("frame_valid", 32'(frame_valid), 32'(st.fv));
        chk("z_hold", {16'd0, z3, z2, z1, z0}, {16'd0, st.z});
        if (frame_valid === 1'b1 || sync_err === 1'b1)
          chk("fv_se_exclusive", 32'(frame_valid & sync_err), 32'd0);
      end
    end
  end

  initial begin
    bit r, v, s;
    int ts;
    step(1, 0, 0, 4'h0); step(1, 1, 1, 4'h9);
    // Basic frame, then idle gaps inside a frame.
    frame4(4'h1, 4'h2, 4'h3, 4'h4); idle(2);
    step(0, 1, 1, 4'hA); step(0, 1, 0, 4'hB); idle(3);
    step(0, 1, 0, 4'hC); step(0, 1, 0, 4'hD); idle(2);
    // Early marker drops 5,6; next frame 7,8,9,A.
    step(0, 1, 1, 4'h5); step(0, 1, 0, 4'h6);
    frame4(4'h7, 4'h8, 4'h9, 4'hA); idle(1);
    // Unmarked sample at slot 0 loses lock; then relock.
    step(0, 1, 0, 4'hE); idle(1); frame4(4'h4, 4'h3, 4'h2, 4'h1); idle(1);
    // Pre-sync samples discarded after reset.
    step(1, 0, 0, 4'h0); step(0, 1, 0, 4'hF); step(0, 1, 0, 4'hE);
    frame4(4'h1, 4'h2, 4'h3, 4'h4); idle(1);
    // Reset in the middle of a frame.
    step(0, 1, 1, 4'h6); step(0, 1, 0, 4'h7); step(0, 1, 0, 4'h8);
    step(1, 1, 0, 4'h9); step(0, 1, 0, 4'h5);
    frame4(4'hC, 4'h0, 4'hF, 4'h3); idle(2);
    // Random traffic, mostly well-framed with occasional violations and resets.
    ts = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = (ts == 0);
      if ($urandom_range(0, 9) == 0) s = !s;
      if (v) ts = (ts + 1) % 4;
      if (r) ts = 0;
      step(r, v, s, 4'($urandom));
    end
    idle(4);
    @(negedge clk);
    chk("frame_queue_drained", 32'(fq.size()), 32'd0);
    chk("status_queue_drained", 32'(sq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter: W, default 4, lane data width in bits.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: din  input  W  time-multiplexed sample, one per accepted cycle.
REQ-005 Port: in_valid  input  1  din valid this cycle; sample accepted when 1.
REQ-006 Port: in_sync  input  1  frame marker; qualified by in_valid; marks sample as slot 0.
REQ-007 Port: z0  output  W  lane 0 output register; z1, z2, z3 identical for slots 1-3.
REQ-008 Port: frame_valid  output  1  one-cycle pulse; z0..z3 updated this cycle.
REQ-009 Port: locked  output  1  1 in LOCK state.
REQ-010 Port: sync_err  output  1  one-cycle pulse on a framing violation.
REQ-011 Port: slot  output  2  slot index expected for the next accepted sample.

Function
REQ-012 The block SHALL demultiplex a 4-slot TDM stream (slot order 0,1,2,3) into 4 lanes, the inverse of the team's 4:1 select mux.
REQ-013 The FSM SHALL have two states, HUNT and LOCK; cycles with in_valid=0 SHALL change no state, counter, or shadow register.
REQ-014 In HUNT: samples without in_sync SHALL be discarded; a sample with in_sync SHALL be stored in shadow slot 0, with slot<=1 and state<=LOCK.
REQ-015 In LOCK with slot=k, k in 1..2, and in_sync=0: sample SHALL be stored to shadow[k], with slot<=k+1.
REQ-016 In LOCK with slot=3 and in_sync=0: z0..z2<=shadow[0..2], z3<=din, frame_valid=1 the next cycle, slot<=0; latency is 1 cycle from the slot-3 accept edge.
REQ-017 In LOCK with slot=0: in_sync=1 SHALL store to shadow[0] with slot<=1; in_sync=0 SHALL discard the sample, pulse sync_err, and go to HUNT with slot<=0.
REQ-018 In LOCK with slot in 1..3 and in_sync=1 (early marker): sync_err SHALL pulse, the partial frame SHALL be dropped without a frame_valid, the sample SHALL be stored as shadow[0], slot<=1, and the state SHALL remain LOCK.
REQ-019 z0..z3 SHALL hold their value between frames and change only on a frame_valid cycle.
REQ-020 frame_valid and sync_err SHALL be registered, at most one cycle wide, and never asserted in the same cycle.
REQ-021 slot SHALL wrap 3->0 modulo 4; no other wrap behaviour exists.
REQ-022 in_sync with in_valid=0 SHALL be ignored.

Reset
REQ-023 On a clk edge with rst=1: state<=HUNT, slot<=0, z0..z3<=0, shadow registers<=0, frame_valid<=0, sync_err<=0, locked<=0.
REQ-024 rst SHALL override all inputs on the same edge; a frame in progress SHALL be discarded with no frame_valid.
REQ-025 After rst deasserts, the block SHALL stay in HUNT until the first in_sync sample.

Verification
REQ-026 Stimulus: rst then din 1,2,3,4 on consecutive in_valid cycles with in_sync on the first. Required: one cycle later z0..z3=1,2,3,4, frame_valid=1 for 1 cycle, locked=1.
REQ-027 Stimulus: idle gaps (in_valid=0 for 3 cycles) between slots 1 and 2 of frame A,B,C,D. Required: z=A,B,C,D, frame_valid exactly once, slot held during the gaps.
REQ-028 Stimulus: while locked, samples 5,6 (sync on 5), then 7 with in_sync, then 8,9,A. Required: sync_err pulse once, no frame for 5,6, next frame z=7,8,9,A.
REQ-029 Stimulus: while locked at slot 0, a sample with in_sync=0. Required: sync_err=1, locked=0, z unchanged; the next sync frame relocks.
REQ-030 Stimulus: pre-sync samples F,E, then a sync frame 1,2,3,4. Required: F,E discarded, z=1,2,3,4.
REQ-031 Stimulus: rst asserted after slot 2 of a frame. Required: all outputs 0, locked=0, no frame_valid, the following sync frame decoded correctly.
